// File: rtl/line_clear_ctrl.sv
// Line-clear sequencer: scans the board for full rows, flashes them, compacts the
// surviving rows downward and back-fills the top with empty rows.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// S_IDLE    | waiting for start
// S_SCAN    | read rows 0..Y_SIZE-1, capture full-row mask one cycle later
// S_FLASH   | present full_mask to the display for FLASH_CYCLES clocks
// S_COMPACT | walk src bottom-up, copy surviving rows to dst (+1 drain cycle)
// S_FILL    | write EMPTY to rows dst..0
// S_DONE    | one-cycle done pulse, num_lines updated
module line_clear_ctrl #(
    parameter int X_SIZE       = 10,
    parameter int Y_SIZE       = 20,
    parameter int CW           = 3,
    parameter int FLASH_CYCLES = 16
) (
    input  logic                   Clk,
    input  logic                   Reset_n,
    input  logic                   start,
    output logic                   busy,
    output logic                   done,
    output logic [4:0]             num_lines,
    output logic [4:0]             rd_row,
    input  logic [X_SIZE*CW-1:0]   rd_data,
    output logic                   wr_en,
    output logic [4:0]             wr_row,
    output logic [X_SIZE*CW-1:0]   wr_data,
    output logic                   flash,
    output logic [Y_SIZE-1:0]      full_mask
);

    localparam int              TW     = (FLASH_CYCLES > 1) ? $clog2(FLASH_CYCLES) : 1;
    localparam logic [4:0]      Y_LAST = 5'(Y_SIZE - 1);
    localparam logic [4:0]      Y_END  = 5'(Y_SIZE);
    localparam logic [TW-1:0]   F_LOAD = TW'(FLASH_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_SCAN, S_FLASH, S_COMPACT, S_FILL, S_DONE
    } state_t;

    state_t            state, state_nxt;
    logic [4:0]        cnt, cnt_nxt;
    logic [TW-1:0]     timer, timer_nxt;
    logic [Y_SIZE-1:0] mask, mask_nxt;
    logic [4:0]        count, count_nxt;
    logic [4:0]        dst, dst_nxt;
    logic              pend, pend_nxt;
    logic [4:0]        num_q, num_nxt;
    logic              row_full;
    logic [4:0]        cnt_m1;
    logic [4:0]        src;

    assign cnt_m1 = cnt - 5'd1;
    assign src    = Y_LAST - cnt;

    always_comb begin
        row_full = 1'b1;
        for (int c = 0; c < X_SIZE; c++) begin
            if (rd_data[c*CW +: CW] == '0) row_full = 1'b0;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= S_IDLE;
            cnt   <= '0;
            timer <= '0;
            mask  <= '0;
            count <= '0;
            dst   <= '0;
            pend  <= 1'b0;
            num_q <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            timer <= timer_nxt;
            mask  <= mask_nxt;
            count <= count_nxt;
            dst   <= dst_nxt;
            pend  <= pend_nxt;
            num_q <= num_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        timer_nxt = timer;
        mask_nxt  = mask;
        count_nxt = count;
        dst_nxt   = dst;
        pend_nxt  = 1'b0;
        num_nxt   = num_q;
        rd_row    = '0;
        wr_en     = 1'b0;
        wr_row    = '0;
        wr_data   = '0;
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_SCAN;
                    cnt_nxt   = '0;
                    mask_nxt  = '0;
                    count_nxt = '0;
                end
            end
            S_SCAN: begin
                if (cnt < Y_END) rd_row = cnt;
                // data for row cnt-1 arrives this cycle
                if (cnt != '0 && row_full) begin
                    mask_nxt[cnt_m1] = 1'b1;
                    count_nxt        = count + 5'd1;
                end
                cnt_nxt = cnt + 5'd1;
                if (cnt == Y_END) begin
                    if (mask_nxt == '0) begin
                        state_nxt = S_DONE;
                        num_nxt   = '0;
                    end else begin
                        state_nxt = S_FLASH;
                        timer_nxt = F_LOAD;
                    end
                end
            end
            S_FLASH: begin
                if (timer == '0) begin
                    state_nxt = S_COMPACT;
                    cnt_nxt   = '0;
                    dst_nxt   = Y_LAST;
                end else begin
                    timer_nxt = timer - TW'(1);
                end
            end
            S_COMPACT: begin
                if (pend) begin
                    wr_en   = 1'b1;
                    wr_row  = dst;
                    wr_data = rd_data;
                    dst_nxt = dst - 5'd1;
                end
                if (cnt < Y_END && !mask[src]) begin
                    rd_row   = src;
                    pend_nxt = 1'b1;
                end
                cnt_nxt = cnt + 5'd1;
                if (cnt == Y_END) state_nxt = S_FILL;
            end
            S_FILL: begin
                wr_en  = 1'b1;
                wr_row = dst;
                // stop at row 0 so dst never wraps into a real row
                if (dst == '0) begin
                    state_nxt = S_DONE;
                    num_nxt   = count;
                end else begin
                    dst_nxt = dst - 5'd1;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE);
    assign flash     = (state == S_FLASH);
    assign full_mask = flash ? mask : '0;
    assign num_lines = num_q;

endmodule

// File: tb/tb_line_clear_ctrl.sv
// Bench for line_clear_ctrl: board RAM model plus a cycle-timeline reference
// derived from the clear-pass rules, checked on every negedge.
module tb_line_clear_ctrl;
    localparam int X  = 10;
    localparam int Y  = 20;
    localparam int CW = 3;
    localparam int F  = 16;
    localparam int RW = X * CW;
    localparam int TL = 128;

    logic          Clk = 1'b0;
    logic          Reset_n;
    logic          start;
    logic          busy, done, wr_en, flash;
    logic [4:0]    num_lines, rd_row, wr_row;
    logic [RW-1:0] rd_data, wr_data;
    logic [Y-1:0]  full_mask;

    line_clear_ctrl #(.X_SIZE(X), .Y_SIZE(Y), .CW(CW), .FLASH_CYCLES(F)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .start(start), .busy(busy), .done(done),
        .num_lines(num_lines), .rd_row(rd_row), .rd_data(rd_data), .wr_en(wr_en),
        .wr_row(wr_row), .wr_data(wr_data), .flash(flash), .full_mask(full_mask)
    );

    always #5 Clk = ~Clk;

    logic [RW-1:0] mem        [0:Y-1];
    logic [RW-1:0] init_board [0:Y-1];
    logic [RW-1:0] exp_board  [0:Y-1];
    logic          load;

    always @(posedge Clk) begin
        rd_data <= (rd_row < 5'(Y)) ? mem[rd_row] : '0;
        if (load) begin
            for (int i = 0; i < Y; i++) mem[i] <= init_board[i];
        end else if (wr_en) begin
            mem[wr_row] <= wr_data;
        end
    end

    // expected timeline, indexed by cycles after the start cycle
    logic          e_busy  [0:TL-1];
    logic          e_done  [0:TL-1];
    logic          e_flash [0:TL-1];
    logic [Y-1:0]  e_mask  [0:TL-1];
    logic          e_wr    [0:TL-1];
    logic [4:0]    e_wrow  [0:TL-1];
    logic [RW-1:0] e_wdata [0:TL-1];
    logic          e_rcare [0:TL-1];
    logic [4:0]    e_rrow  [0:TL-1];
    logic [4:0]    e_num   [0:TL-1];

    int cyc = 0;
    int t_cyc, t_len, last_n, prev_n;
    int tests = 0, fails = 0;
    int done_pulses, flash_cnt, wr_cnt, dut_done_k;
    logic [Y-1:0] last_mask;

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit is_full(input logic [RW-1:0] row);
        for (int c = 0; c < X; c++) if (row[c*CW +: CW] == '0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic build_trace();
        logic [RW-1:0] q[$];
        logic [Y-1:0]  m;
        int n, d, k;
        m = '0;
        for (int r = 0; r < Y; r++) begin
            if (is_full(init_board[r])) m[r] = 1'b1;
            else q.push_back(init_board[r]);
        end
        n = Y - q.size();
        for (int r = 0; r < Y; r++) exp_board[r] = (r < n) ? '0 : q[r-n];
        for (int i = 0; i < TL; i++) begin
            e_busy[i] = 0; e_done[i] = 0; e_flash[i] = 0; e_mask[i] = '0;
            e_wr[i] = 0; e_wrow[i] = '0; e_wdata[i] = '0; e_rcare[i] = 0; e_rrow[i] = '0;
        end
        for (int r = 0; r < Y; r++) begin
            e_rcare[1+r] = 1; e_rrow[1+r] = 5'(r);
        end
        if (n == 0) begin
            t_len = Y + 2;
        end else begin
            for (int i = 0; i < F; i++) begin
                e_flash[Y+2+i] = 1; e_mask[Y+2+i] = m;
            end
            d = Y - 1;
            for (int i = 0; i < Y; i++) begin
                k = Y + 2 + F + i;
                if (!m[Y-1-i]) begin
                    e_rcare[k] = 1; e_rrow[k] = 5'(Y-1-i);
                    e_wr[k+1] = 1; e_wrow[k+1] = 5'(d); e_wdata[k+1] = init_board[Y-1-i];
                    d--;
                end
            end
            for (int j = 0; j < n; j++) begin
                k = 2*Y + 3 + F + j;
                e_wr[k] = 1; e_wrow[k] = 5'(n-1-j); e_wdata[k] = '0;
            end
            t_len = 2*Y + 3 + F + n;
        end
        for (int i = 1; i <= t_len; i++) e_busy[i] = 1;
        e_done[t_len] = 1;
        prev_n = last_n;
        last_n = n;
        for (int i = 0; i < TL; i++) e_num[i] = (i >= t_len) ? 5'(n) : 5'(prev_n);
    endtask

    always @(negedge Clk) begin
        int k;
        k = cyc - t_cyc;
        if (done) begin done_pulses++; dut_done_k = k; end
        if (flash) begin flash_cnt++; last_mask = full_mask; end
        if (wr_en) wr_cnt++;
        if (k >= 1 && k <= t_len) begin
            chk("busy", 64'(busy), 64'(e_busy[k]));
            chk("done", 64'(done), 64'(e_done[k]));
            chk("flash", 64'(flash), 64'(e_flash[k]));
            chk("full_mask", 64'(full_mask), 64'(e_mask[k]));
            chk("wr_en", 64'(wr_en), 64'(e_wr[k]));
            chk("num_lines", 64'(num_lines), 64'(e_num[k]));
            if (e_wr[k]) begin
                chk("wr_row", 64'(wr_row), 64'(e_wrow[k]));
                chk("wr_data", 64'(wr_data), 64'(e_wdata[k]));
            end
            if (e_rcare[k]) chk("rd_row", 64'(rd_row), 64'(e_rrow[k]));
        end else begin
            chk("idle_busy", 64'(busy), 64'd0);
            chk("idle_done", 64'(done), 64'd0);
            chk("idle_flash", 64'(flash), 64'd0);
            chk("idle_wr_en", 64'(wr_en), 64'd0);
            chk("idle_num", 64'(num_lines), (k > t_len) ? 64'(last_n) : 64'(prev_n));
        end
    end

    task automatic load_board();
        @(posedge Clk); #1 load = 1'b1;
        @(posedge Clk); #1 load = 1'b0;
    endtask

    task automatic run_pass(input bit pulse);
        load_board();
        build_trace();
        done_pulses = 0; flash_cnt = 0; wr_cnt = 0; dut_done_k = -1;
        start = 1'b1;
        t_cyc = cyc;
        for (int i = 1; i <= t_len + 1; i++) begin
            @(posedge Clk); #1;
            start = pulse && (i == 24 || i == 44 || i == 45);
        end
        for (int r = 0; r < Y; r++) chk($sformatf("board_row%0d", r), 64'(mem[r]), 64'(exp_board[r]));
        chk("done_cycle", 64'(dut_done_k), 64'(t_len));
        chk("done_pulses", 64'(done_pulses), 64'd1);
    endtask

    function automatic logic [RW-1:0] full_row(input int r);
        logic [RW-1:0] v;
        for (int c = 0; c < X; c++) v[c*CW +: CW] = CW'((r + c) % 7 + 1);
        return v;
    endfunction

    function automatic logic [RW-1:0] part_row(input int r);
        logic [RW-1:0] v;
        v = full_row(r);
        v[(r % X)*CW +: CW] = '0;
        return v;
    endfunction

    task automatic board_four();
        for (int r = 0; r < Y; r++)
            init_board[r] = (r == 10 || r == 15 || r == 17 || r == 19) ? full_row(r) : part_row(r);
    endtask

    initial begin
        Reset_n = 1'b0; start = 1'b0; load = 1'b0;
        t_cyc = -100000; t_len = 0; last_n = 0; prev_n = 0;
        done_pulses = 0; flash_cnt = 0; wr_cnt = 0; dut_done_k = -1; last_mask = '0;
        for (int r = 0; r < Y; r++) init_board[r] = '0;
        load_board();
        repeat (2) @(posedge Clk);
        #1 Reset_n = 1'b1;

        // empty board
        run_pass(0);
        chk("empty_done_at_22", 64'(dut_done_k), 64'd22);
        chk("empty_flash_cycles", 64'(flash_cnt), 64'd0);
        chk("empty_writes", 64'(wr_cnt), 64'd0);
        chk("empty_num", 64'(num_lines), 64'd0);

        // bottom row full, single cell at column 3 on row 18
        for (int r = 0; r < Y; r++) init_board[r] = '0;
        init_board[19] = full_row(19);
        init_board[18] = 30'h0000_0A00;
        run_pass(0);
        chk("one_mask", 64'(last_mask), 64'h80000);
        chk("one_flash_cycles", 64'(flash_cnt), 64'd16);
        chk("one_done_at_60", 64'(dut_done_k), 64'd60);
        chk("one_row19", 64'(mem[19]), 64'h0A00);
        chk("one_row0", 64'(mem[0]), 64'd0);
        chk("one_num", 64'(num_lines), 64'd1);

        // four full rows
        board_four();
        run_pass(0);
        chk("four_num", 64'(num_lines), 64'd4);
        chk("four_writes", 64'(wr_cnt), 64'd20);
        chk("four_done_at_63", 64'(dut_done_k), 64'd63);

        // all rows full
        for (int r = 0; r < Y; r++) init_board[r] = full_row(r);
        run_pass(0);
        chk("all_num", 64'(num_lines), 64'd20);
        chk("all_writes", 64'(wr_cnt), 64'd20);
        chk("all_done_at_79", 64'(dut_done_k), 64'd79);

        // start pulses during FLASH and COMPACT are ignored
        board_four();
        run_pass(1);
        chk("pulse_num", 64'(num_lines), 64'd4);

        // reset in the middle of COMPACT
        board_four();
        load_board();
        build_trace();
        start = 1'b1;
        t_cyc = cyc;
        for (int i = 1; i <= 45; i++) begin
            @(posedge Clk); #1 start = 1'b0;
        end
        Reset_n = 1'b0;
        t_cyc = -100000; t_len = 0; last_n = 0; prev_n = 0;
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_wr_en", 64'(wr_en), 64'd0);
        chk("rst_flash", 64'(flash), 64'd0);
        chk("rst_num", 64'(num_lines), 64'd0);
        @(posedge Clk); #1 Reset_n = 1'b1;
        board_four();
        run_pass(0);
        chk("post_rst_num", 64'(num_lines), 64'd4);

        // random boards
        for (int p = 0; p < 30; p++) begin
            for (int r = 0; r < Y; r++) begin
                for (int c = 0; c < X; c++) init_board[r][c*CW +: CW] = CW'($urandom_range(1, 7));
                if ($urandom_range(0, 99) >= 35)
                    init_board[r][$urandom_range(0, X-1)*CW +: CW] = '0;
            end
            run_pass(1'($urandom_range(0, 1)));
        end

        repeat (3) @(posedge Clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
